// File: rtl/vid_timing_pkg.sv
// Video timing constants, derived totals and reader FSM states shared by the frame reader.
// Defaults describe 720p60; all consumers take them as overridable parameters.
package vid_timing_pkg;

  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 110;
  localparam int H_SYNC   = 40;
  localparam int H_BP     = 220;
  localparam int V_ACTIVE = 720;
  localparam int V_FP     = 5;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 20;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W    = 12;
  localparam int STAT_W   = 16;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_DROP   = 2'd2
  } rd_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// Pixel/line counters with combinational S0 region flags (active, hsync, vsync, frame start).
// Free-running; no backpressure, flags change in the same cycle as the counters.
module vid_timing_cnt
  import vid_timing_pkg::*;
#(
  parameter int C_H_ACTIVE = H_ACTIVE,
  parameter int C_H_FP     = H_FP,
  parameter int C_H_SYNC   = H_SYNC,
  parameter int C_H_TOTAL  = H_TOTAL,
  parameter int C_V_ACTIVE = V_ACTIVE,
  parameter int C_V_FP     = V_FP,
  parameter int C_V_SYNC   = V_SYNC,
  parameter int C_V_TOTAL  = V_TOTAL
) (
  input  logic vid_clk,
  input  logic vid_reset,
  output logic active,
  output logic hs_region,
  output logic vs_region,
  output logic frame_start
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(C_H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(C_V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(C_H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(C_V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(C_H_ACTIVE + C_H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(C_H_ACTIVE + C_H_FP + C_H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(C_V_ACTIVE + C_V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(C_V_ACTIVE + C_V_FP + C_V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  always_ff @(posedge vid_clk or posedge vid_reset) begin
    if (vid_reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_region   = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_region   = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/hdmi_frame_reader.sv
// Generates video timing, paces the frame-buffer reader and drives registered RGB/HS/VS/DE.
// Counter position reaches vid_* 3 cycles later; reader underflow blanks the rest of the frame.
module hdmi_frame_reader
  import vid_timing_pkg::*;
#(
  parameter int          C_R_WIDTH       = 24,
  parameter int          C_H_ACTIVE      = H_ACTIVE,
  parameter int          C_H_FP          = H_FP,
  parameter int          C_H_SYNC        = H_SYNC,
  parameter int          C_H_BP          = H_BP,
  parameter int          C_V_ACTIVE      = V_ACTIVE,
  parameter int          C_V_FP          = V_FP,
  parameter int          C_V_SYNC        = V_SYNC,
  parameter int          C_V_BP          = V_BP,
  parameter bit          C_HS_POL        = 1'b1,
  parameter bit          C_VS_POL        = 1'b1,
  parameter int          C_WARMUP_FRAMES = 2,
  parameter logic [23:0] C_FILL_RGB      = 24'h000000
) (
  input  logic                 vid_clk,
  input  logic                 vid_reset,
  output logic                 rframe_vsync,
  output logic                 rframe_data_en,
  input  logic                 rframe_data_valid,
  input  logic [C_R_WIDTH-1:0] rframe_data,
  output logic                 vid_hs,
  output logic                 vid_vs,
  output logic                 vid_de,
  output logic [23:0]          vid_rgb,
  output logic [STAT_W-1:0]    stat_drop_cnt,
  output logic                 stat_underflow
);

  localparam int H_TOT = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;
  localparam int V_TOT = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;
  localparam int WU_W  = (C_WARMUP_FRAMES < 1) ? 1 : $clog2(C_WARMUP_FRAMES + 1);
  localparam logic [WU_W-1:0] WU_TGT = WU_W'(C_WARMUP_FRAMES);

  // S0 flags
  logic s0_active;
  logic s0_hs;
  logic s0_vs;
  logic s0_fs;

  // S1/S2 pipeline
  logic s1_active;
  logic s1_hs;
  logic s1_vs;
  logic s2_active;
  logic s2_hs;
  logic s2_vs;
  logic s2_en;

  rd_state_e       state;
  rd_state_e       state_nxt;
  logic [WU_W-1:0] warm_cnt;
  logic [WU_W-1:0] warm_cnt_nxt;
  logic            underflow;

  vid_timing_cnt #(
    .C_H_ACTIVE (C_H_ACTIVE),
    .C_H_FP     (C_H_FP),
    .C_H_SYNC   (C_H_SYNC),
    .C_H_TOTAL  (H_TOT),
    .C_V_ACTIVE (C_V_ACTIVE),
    .C_V_FP     (C_V_FP),
    .C_V_SYNC   (C_V_SYNC),
    .C_V_TOTAL  (V_TOT)
  ) u_cnt (
    .vid_clk     (vid_clk),
    .vid_reset   (vid_reset),
    .active      (s0_active),
    .hs_region   (s0_hs),
    .vs_region   (s0_vs),
    .frame_start (s0_fs)
  );

  always_ff @(posedge vid_clk or posedge vid_reset) begin
    if (vid_reset) begin
      s1_active <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s2_active <= 1'b0;
      s2_hs     <= 1'b0;
      s2_vs     <= 1'b0;
      s2_en     <= 1'b0;
    end else begin
      s1_active <= s0_active;
      s1_hs     <= s0_hs;
      s1_vs     <= s0_vs;
      s2_active <= s1_active;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
      s2_en     <= rframe_data_en;
    end
  end

  // Raw region flag, not polarity-adjusted: the reader keys its fetch off the falling edge.
  assign rframe_vsync = s1_vs;

  always_ff @(posedge vid_clk or posedge vid_reset) begin
    if (vid_reset) begin
      state    <= ST_WARMUP;
      warm_cnt <= '0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_cnt_nxt;
    end
  end

  // Frame start is taken from S0 so the new state is in place when S1 holds pixel 0.
  always_comb begin
    state_nxt      = state;
    warm_cnt_nxt   = warm_cnt;
    rframe_data_en = 1'b0;
    underflow      = 1'b0;
    case (state)
      ST_WARMUP: begin
        if (s0_fs) begin
          if (warm_cnt == WU_TGT) begin
            state_nxt = ST_RUN;
          end else begin
            warm_cnt_nxt = warm_cnt + WU_W'(1);
          end
        end
      end
      ST_RUN: begin
        rframe_data_en = s1_active & rframe_data_valid;
        if (s1_active && !rframe_data_valid) begin
          underflow = 1'b1;
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (s0_fs) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_WARMUP;
    endcase
  end

  always_ff @(posedge vid_clk or posedge vid_reset) begin
    if (vid_reset) begin
      vid_hs  <= ~C_HS_POL;
      vid_vs  <= ~C_VS_POL;
      vid_de  <= 1'b0;
      vid_rgb <= C_FILL_RGB;
    end else begin
      vid_hs  <= s2_hs ? C_HS_POL : ~C_HS_POL;
      vid_vs  <= s2_vs ? C_VS_POL : ~C_VS_POL;
      vid_de  <= s2_active;
      vid_rgb <= s2_en ? 24'(rframe_data) : C_FILL_RGB;
    end
  end

  always_ff @(posedge vid_clk or posedge vid_reset) begin
    if (vid_reset) begin
      stat_drop_cnt  <= '0;
      stat_underflow <= 1'b0;
    end else if (underflow) begin
      stat_drop_cnt  <= sat_inc(stat_drop_cnt);
      stat_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hdmi_frame_reader.sv
// Directed bench for hdmi_frame_reader on a shrunken raster, checked every cycle against a
// position-based model plus hand-computed timing and pixel literals.
module tb_hdmi_frame_reader;

  localparam int HA = 16, HFP = 3, HSY = 4, HBP = 5;
  localparam int VA = 6,  VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;   // 28
  localparam int VT = VA + VFP + VSY + VBP;   // 13
  localparam int FT = HT * VT;                // 364
  localparam int WU = 2;
  localparam logic [23:0] FILL = 24'hC0FFEE;

  logic        vid_clk = 1'b0;
  logic        vid_reset = 1'b1;
  logic        rframe_vsync;
  logic        rframe_data_en;
  logic        rframe_data_valid = 1'b1;
  logic [23:0] rframe_data = '0;
  logic        vid_hs, vid_vs, vid_de;
  logic [23:0] vid_rgb;
  logic [15:0] stat_drop_cnt;
  logic        stat_underflow;

  always #5 vid_clk = ~vid_clk;

  hdmi_frame_reader #(
    .C_R_WIDTH       (24),
    .C_H_ACTIVE      (HA),
    .C_H_FP          (HFP),
    .C_H_SYNC        (HSY),
    .C_H_BP          (HBP),
    .C_V_ACTIVE      (VA),
    .C_V_FP          (VFP),
    .C_V_SYNC        (VSY),
    .C_V_BP          (VBP),
    .C_HS_POL        (1'b1),
    .C_VS_POL        (1'b1),
    .C_WARMUP_FRAMES (WU),
    .C_FILL_RGB      (FILL)
  ) dut (
    .vid_clk           (vid_clk),
    .vid_reset         (vid_reset),
    .rframe_vsync      (rframe_vsync),
    .rframe_data_en    (rframe_data_en),
    .rframe_data_valid (rframe_data_valid),
    .rframe_data       (rframe_data),
    .vid_hs            (vid_hs),
    .vid_vs            (vid_vs),
    .vid_de            (vid_de),
    .vid_rgb           (vid_rgb),
    .stat_drop_cnt     (stat_drop_cnt),
    .stat_underflow    (stat_underflow)
  );

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;

  // literal-monitor captures (first phase only)
  int first_en = -1, vs_fall = -1, de_r0 = -1, de_r1 = -1, hs_r = -1, hs_f = -1;
  int vs_r0 = -1, vs_r1 = -1, de_cnt = 0, en_cnt_starved = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  function automatic bit is_active(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic bit is_hs(input int p);
    return ((p % HT) >= HA + HFP) && ((p % HT) < HA + HFP + HSY);
  endfunction

  function automatic bit is_vs(input int p);
    return ((p / HT) >= VA + VFP) && ((p / HT) < VA + VFP + VSY);
  endfunction

  // Reader content: frame number in the top byte, raster pixel index below.
  function automatic logic [23:0] pix(input int q);
    int f, p, idx;
    logic [7:0] fb;
    logic [15:0] ib;
    f = q / FT;
    p = q % FT;
    idx = (p / HT) * HA + (p % HT);
    fb = 8'(f);
    ib = 16'(idx);
    return {fb, ib};
  endfunction

  // Underflow stimulus: one starved pixel in frame 3 (line 3, pixel 7), frames 5-7 fully starved.
  function automatic bit valid_at(input int kk);
    int q, f, p;
    if (kk < 1) return 1'b1;
    q = kk - 1;
    f = q / FT;
    p = q % FT;
    if (f == 3 && p == 3 * HT + 7) return 1'b0;
    if (f >= 5 && f <= 7) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_vid_de"},  {31'd0, vid_de}, 32'd0);
    check({tag, "_vid_hs"},  {31'd0, vid_hs}, 32'd0);
    check({tag, "_vid_vs"},  {31'd0, vid_vs}, 32'd0);
    check({tag, "_vid_rgb"}, {8'd0, vid_rgb}, {8'd0, FILL});
    check({tag, "_rvsync"},  {31'd0, rframe_vsync}, 32'd0);
    check({tag, "_rd_en"},   {31'd0, rframe_data_en}, 32'd0);
    check({tag, "_drops"},   {16'd0, stat_drop_cnt}, 32'd0);
    check({tag, "_uflow"},   {31'd0, stat_underflow}, 32'd0);
  endtask

  // Entered at a falling edge in cycle 0 (counters at 0); one iteration per clock.
  task automatic run_phase(input int ncyc, input bit phase_a);
    int  q, f, p, p3, exp_drop, dropped_frame;
    bit  exp_uf, valid, exp_en, uf_event, en_m1, en_m2;
    bit  pv_rvs, pv_de, pv_hs, pv_vs;
    logic [23:0] dat_m1, exp_rgb;
    exp_drop = 0; dropped_frame = -1; exp_uf = 0;
    en_m1 = 0; en_m2 = 0; dat_m1 = '0;
    pv_rvs = 0; pv_de = 0; pv_hs = 0; pv_vs = 0;
    for (int kk = 0; kk < ncyc; kk++) begin
      k = kk;
      valid = phase_a ? valid_at(kk) : 1'b1;
      rframe_data_valid = valid;
      rframe_data = (kk >= 2) ? pix(kk - 2) : 24'd0;
      #1;
      exp_en = 0;
      uf_event = 0;
      f = -1;
      if (kk >= 1) begin
        q = kk - 1;
        f = q / FT;
        p = q % FT;
        if (f >= WU && is_active(p) && dropped_frame != f) begin
          if (valid) exp_en = 1;
          else uf_event = 1;
        end
      end
      exp_rgb = en_m2 ? dat_m1 : FILL;
      check("rd_en", {31'd0, rframe_data_en}, {31'd0, exp_en});
      check("rvsync", {31'd0, rframe_vsync},
            {31'd0, (kk >= 1) ? is_vs((kk - 1) % FT) : 1'b0});
      p3 = (kk >= 3) ? (kk - 3) % FT : 0;
      check("vid_de", {31'd0, vid_de}, {31'd0, (kk >= 3) ? is_active(p3) : 1'b0});
      check("vid_hs", {31'd0, vid_hs}, {31'd0, (kk >= 3) ? is_hs(p3) : 1'b0});
      check("vid_vs", {31'd0, vid_vs}, {31'd0, (kk >= 3) ? is_vs(p3) : 1'b0});
      check("vid_rgb", {8'd0, vid_rgb}, {8'd0, exp_rgb});
      check("drop_cnt", {16'd0, stat_drop_cnt}, exp_drop);
      check("underflow", {31'd0, stat_underflow}, {31'd0, exp_uf});

      if (phase_a) begin
        if (rframe_data_en && first_en < 0) first_en = kk;
        if (!rframe_vsync && pv_rvs && first_en < 0) vs_fall = kk;
        if (vid_de && !pv_de) begin
          if (de_r0 < 0) de_r0 = kk;
          else if (de_r1 < 0) de_r1 = kk;
        end
        if (vid_hs && !pv_hs && de_r0 >= 0 && hs_r < 0) hs_r = kk;
        if (!vid_hs && pv_hs && hs_r >= 0 && hs_f < 0) hs_f = kk;
        if (vid_vs && !pv_vs) begin
          if (vs_r0 < 0) vs_r0 = kk;
          else if (vs_r1 < 0) vs_r1 = kk;
        end
        if (kk >= 2 * FT + 3 && kk < 3 * FT + 3 && vid_de) de_cnt++;
        if (kk >= 5 * FT + 1 && kk < 8 * FT + 1 && rframe_data_en) en_cnt_starved++;
        if (kk == 2 * FT + 3)
          check("frame2_pixel0", {8'd0, vid_rgb}, 32'h00020000);
        if (kk == 2 * FT + HT + 3)
          check("frame2_line1_pixel0", {8'd0, vid_rgb}, 32'h00020010);
        if (kk == 3 * FT + 3 * HT + 6 + 3)
          check("pixel_before_drop", {8'd0, vid_rgb}, 32'h00030036);
        if (kk == 3 * FT + 3 * HT + 7 + 3) begin
          check("drop_pixel_fill", {8'd0, vid_rgb}, {8'd0, FILL});
          check("drop_pixel_de", {31'd0, vid_de}, 32'd1);
        end
        if (kk == 3 * FT + 5 * HT + 3)
          check("drop_rest_fill", {8'd0, vid_rgb}, {8'd0, FILL});
        if (kk == 4 * FT) begin
          check("drops_after_f3", {16'd0, stat_drop_cnt}, 32'd1);
          check("uflow_after_f3", {31'd0, stat_underflow}, 32'd1);
        end
        if (kk == 4 * FT + 3)
          check("frame4_resume", {8'd0, vid_rgb}, 32'h00040000);
        if (kk == 8 * FT + 1)
          check("drops_after_starve", {16'd0, stat_drop_cnt}, 32'd4);
      end
      pv_rvs = rframe_vsync; pv_de = vid_de; pv_hs = vid_hs; pv_vs = vid_vs;

      if (uf_event) begin
        dropped_frame = f;
        exp_uf = 1;
        if (exp_drop < 65535) exp_drop++;
      end
      en_m2 = en_m1;
      en_m1 = exp_en;
      dat_m1 = rframe_data;
      @(negedge vid_clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge vid_clk);
    check_reset_vals("rst0");
    vid_reset = 1'b0;
    // frames 0..8, stop at frame 9 line 3 pixel 10
    run_phase(9 * FT + 3 * HT + 10, 1'b1);
    check("first_en_cycle", first_en, 2 * FT + 1);
    check("vsync_fall_lead", first_en - vs_fall, VBP * HT);
    check("h_period", de_r1 - de_r0, HT);
    check("hs_offset", hs_r - de_r0, HA + HFP);
    check("hs_width", hs_f - hs_r, HSY);
    check("v_period", vs_r1 - vs_r0, FT);
    check("de_per_frame", de_cnt, HA * VA);
    check("en_while_starved", en_cnt_starved, 0);
    check("pre_reset_de", {31'd0, vid_de}, 32'd1);
    check("pre_reset_en", {31'd0, rframe_data_en}, 32'd1);
    vid_reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge vid_clk);
    vid_reset = 1'b0;
    run_phase(3 * FT + 10, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
